// File: rtl/cheri_rvfi_trace_buf.sv
`default_nettype none
// ============================================================================
// Module   : cheri_rvfi_trace_buf
// Brief    : RVFI retirement record FIFO streamed out as 32-bit words.
//            Define CHERI_RVFI_TRACE_TS_EN to append an mcycle timestamp word.
// Revision : 1.0
// ============================================================================
module cheri_rvfi_trace_buf #(
    parameter int Depth = 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        trace_en_i,
    input  logic        trace_flush_i,
    input  logic        rvfi_valid,
    input  logic        rvfi_trap,
    input  logic        rvfi_intr,
    input  logic [31:0] rvfi_pc_rdata,
    input  logic [31:0] rvfi_insn,
    input  logic [31:0] rvfi_rd_wdata,
    input  logic [4:0]  rvfi_rd_addr,
    input  logic [63:0] rvfi_order,
    input  logic [63:0] rvfi_ext_mcycle,
    output logic        trace_valid_o,
    input  logic        trace_ready_i,
    output logic [31:0] trace_data_o,
    output logic        trace_last_o,
    output logic [15:0] trace_drop_cnt_o
);

    localparam int c_idx_w = $clog2(Depth);
    localparam int c_ptr_w = c_idx_w + 1;
`ifdef CHERI_RVFI_TRACE_TS_EN
    localparam int c_num_words = 5;
`else
    localparam int c_num_words = 4;
`endif
    localparam int c_word_w = $clog2(c_num_words);
    localparam logic [c_word_w-1:0] c_last_word = c_word_w'(c_num_words - 1);

    logic [c_num_words-1:0][31:0] mem_q [Depth];
    logic [c_num_words-1:0][31:0] w_record;

    logic [c_ptr_w-1:0]  wr_ptr_q, wr_ptr_d;
    logic [c_ptr_w-1:0]  rd_ptr_q, rd_ptr_d;
    logic [c_word_w-1:0] word_idx_q, word_idx_d;
    logic [15:0]         drop_cnt_q, drop_cnt_d;

    logic w_empty, w_full, w_valid, w_last, w_hs, w_pop;
    logic w_push_req, w_push, w_drop;

    // W0 sits in the lowest slot so the word index selects it directly.
`ifdef CHERI_RVFI_TRACE_TS_EN
    assign w_record = {rvfi_ext_mcycle[31:0],
                       rvfi_trap, rvfi_intr, rvfi_rd_addr, rvfi_order[24:0],
                       rvfi_rd_wdata, rvfi_insn, rvfi_pc_rdata};
    logic unused_bits;
    assign unused_bits = ^{rvfi_order[63:25], rvfi_ext_mcycle[63:32]};
`else
    assign w_record = {rvfi_trap, rvfi_intr, rvfi_rd_addr, rvfi_order[24:0],
                       rvfi_rd_wdata, rvfi_insn, rvfi_pc_rdata};
    logic unused_bits;
    assign unused_bits = ^{rvfi_order[63:25], rvfi_ext_mcycle};
`endif

    // The extra pointer MSB tells a full FIFO from an empty one.
    assign w_empty = (wr_ptr_q == rd_ptr_q);
    assign w_full  = (wr_ptr_q[c_ptr_w-1] != rd_ptr_q[c_ptr_w-1]) &&
                     (wr_ptr_q[c_idx_w-1:0] == rd_ptr_q[c_idx_w-1:0]);

    // Outputs are gated by rst_ni so they read zero while reset is held.
    assign w_valid = rst_ni && !w_empty;
    assign w_last  = w_valid && (word_idx_q == c_last_word);
    assign w_hs    = w_valid && trace_ready_i;
    assign w_pop   = w_hs && w_last;

    assign w_push_req = rst_ni && rvfi_valid && trace_en_i && !trace_flush_i;
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_drop     = w_push_req && w_full && !w_pop;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        word_idx_d = word_idx_q;
        drop_cnt_d = drop_cnt_q;
        if (trace_flush_i) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            word_idx_d = '0;
        end else begin
            if (w_push) begin
                wr_ptr_d = wr_ptr_q + c_ptr_w'(1);
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + c_ptr_w'(1);
            end
            if (w_hs) begin
                word_idx_d = w_last ? '0 : word_idx_q + c_word_w'(1);
            end
            if (w_drop && (drop_cnt_q != 16'hFFFF)) begin
                drop_cnt_d = drop_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            word_idx_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            word_idx_q <= word_idx_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            mem_q[wr_ptr_q[c_idx_w-1:0]] <= w_record;
        end
    end

    assign trace_valid_o    = w_valid;
    assign trace_last_o     = w_last;
    assign trace_data_o     = w_valid ? mem_q[rd_ptr_q[c_idx_w-1:0]][word_idx_q] : '0;
    assign trace_drop_cnt_o = rst_ni ? drop_cnt_q : '0;

endmodule
`default_nettype wire

// File: doc/cheri_rvfi_trace_buf.md
CHERI_RVFI_TRACE_BUF -- requirements
Module: cheri_rvfi_trace_buf

Interface
REQ-001 SHALL have parameter Depth, default 8, record FIFO entries (power of 2, 2..64).
REQ-002 SHALL have port clk_i  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_ni  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port trace_en_i  input  1  capture enable.
REQ-005 SHALL have port trace_flush_i  input  1  discard all buffered records.
REQ-006 SHALL have ports rvfi_valid, rvfi_trap, rvfi_intr  input  1 each  RVFI retirement strobe and flags from ibex_top.
REQ-007 SHALL have ports rvfi_pc_rdata, rvfi_insn, rvfi_rd_wdata  input  32 each  retired PC, instruction, rd write data.
REQ-008 SHALL have ports rvfi_rd_addr  input  5, and rvfi_order  input  64  (bits [24:0] used).
REQ-009 SHALL have port rvfi_ext_mcycle  input  64  cycle counter (bits [31:0] used).
REQ-010 SHALL have ports trace_valid_o  output  1, trace_ready_i  input  1, trace_data_o  output  32, trace_last_o  output  1  word stream.
REQ-011 SHALL have port trace_drop_cnt_o  output  16  saturating dropped-record count.

Function
REQ-012 SHALL capture, per retirement, a record: W0=pc_rdata, W1=insn, W2=rd_wdata, W3={trap, intr, rd_addr[4:0], order[24:0]} (MSB first).
REQ-013 SHALL push a record when rvfi_valid=1, trace_en_i=1, trace_flush_i=0, and the FIFO is not full or a pop occurs in the same cycle.
REQ-014 SHALL drop a record whose push conditions fail only due to fullness, incrementing trace_drop_cnt_o by 1 and saturating at 16'hFFFF.
REQ-015 SHALL assert trace_valid_o whenever FIFO non-empty, with trace_data_o = word at current word index of head record.
REQ-016 SHALL advance the word index on trace_valid_o && trace_ready_i, and assert trace_last_o on the final word of a record.
REQ-017 SHALL pop the head record and reset word index to 0 on the handshake of the final word.
REQ-018 SHALL hold trace_data_o and trace_last_o stable while trace_valid_o=1 and trace_ready_i=0.
REQ-019 SHALL have latency 1: a record pushed at edge N into an empty FIFO drives trace_valid_o=1 after edge N.
REQ-020 SHALL, on trace_flush_i=1, empty the FIFO, zero word index, and drop no count; trace_valid_o=0 after that edge; a coincident rvfi_valid is discarded without counting.
REQ-021 SHALL continue draining buffered records when trace_en_i falls mid-stream.
REQ-022 SHALL wrap read/write pointers modulo Depth, using an extra pointer bit to distinguish full from empty.
REQ-023 SHALL support simultaneous push and pop every cycle without loss while occupancy is constant.

Reset
REQ-024 SHALL, when rst_ni=0 at a rising edge, clear pointers, word index and drop counter, regardless of an in-progress record.
REQ-025 SHALL drive trace_valid_o=0, trace_last_o=0, trace_data_o=0, trace_drop_cnt_o=0 during and immediately after reset.
REQ-026 SHALL ignore rvfi_valid in any cycle with rst_ni=0.

Configuration
REQ-027 SHALL, with macro CHERI_RVFI_TRACE_TS_EN defined, append W4=rvfi_ext_mcycle[31:0] sampled at push, making records 5 words with trace_last_o on W4.
REQ-028 SHALL, without CHERI_RVFI_TRACE_TS_EN, emit 4-word records with trace_last_o on W3 and leave rvfi_ext_mcycle unused.

Verification
REQ-029 SHALL cover single retire: pc=0x8000_0000, insn=0x0010_0093, rd=1, wdata=1, order=5, ready=1 -> W0..W3 = 0x80000000, 0x00100093, 0x00000001, 0x02000005, last on W3.
REQ-030 SHALL cover overflow: Depth=8, ready=0, 10 retirements -> 8 buffered, trace_drop_cnt_o=2, then 32 words drained in order.
REQ-031 SHALL cover backpressure: ready toggling 1/0 each cycle -> data stable during stalls, no word duplicated or lost.
REQ-032 SHALL cover full with simultaneous final-word pop and push -> push accepted, drop count unchanged.
REQ-033 SHALL cover flush and reset mid-record (after W1 handshake) -> trace_valid_o=0 next cycle, next record starts at W0.
REQ-034 SHALL cover CHERI_RVFI_TRACE_TS_EN with mcycle=0x1234 at push -> W4=0x00001234, last on W4.
